// File: rtl/core_pkg.sv
// Shared types for the RV32 core: the sequencing FSM state encoding.
package core_pkg;

  localparam int CTRL_STATE_W = 3;

  typedef enum logic [CTRL_STATE_W-1:0] {
    BOUNDARY = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    MEM      = 3'd3,
    WFI      = 3'd4
  } ctrl_state_e;

endpackage : core_pkg

// File: rtl/core_controller_if.sv
// Handshake, decode and commit-strobe bundle between core_controller and the rest of the core.
interface core_controller_if;

  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;
  logic is_load;
  logic is_store;
  logic is_mret;
  logic is_wfi;
  logic has_rd;
  logic exception_valid;
  logic interrupt_valid;
  logic int_pending;
  logic check_interrupt;
  logic instr_en;
  logic pc_en;
  logic rd_en;
  logic retire;
  logic trap_en;
  logic mret_en;

  modport master (
    output imem_req, dmem_req, dmem_we, check_interrupt,
           instr_en, pc_en, rd_en, retire, trap_en, mret_en,
    input  imem_ready, dmem_ready, is_load, is_store, is_mret, is_wfi,
           has_rd, exception_valid, interrupt_valid, int_pending
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, check_interrupt,
           instr_en, pc_en, rd_en, retire, trap_en, mret_en,
    output imem_ready, dmem_ready, is_load, is_store, is_mret, is_wfi,
           has_rd, exception_valid, interrupt_valid, int_pending
  );

endinterface : core_controller_if

// File: rtl/core_controller.sv
// Multi-cycle sequencing FSM: boundary/interrupt check, fetch, execute, optional memory access, WFI sleep.
module core_controller
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  core_controller_if.master bus
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;
  ctrl_state_e cur_state;

  // While rst is high the outputs decode as BOUNDARY so requests drop and no commit leaks out.
  always_comb begin
    cur_state           = rst ? BOUNDARY : state_q;
    state_d             = cur_state;
    bus.imem_req        = 1'b0;
    bus.dmem_req        = 1'b0;
    bus.dmem_we         = 1'b0;
    bus.check_interrupt = 1'b0;
    bus.instr_en        = 1'b0;
    bus.pc_en           = 1'b0;
    bus.rd_en           = 1'b0;
    bus.retire          = 1'b0;
    bus.trap_en         = 1'b0;
    bus.mret_en         = 1'b0;

    case (cur_state)
      BOUNDARY: begin
        bus.check_interrupt = 1'b1;
        if (bus.interrupt_valid) begin
          bus.trap_en = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.instr_en = 1'b1;
          state_d      = EXEC;
        end
      end

      EXEC: begin
        if (bus.exception_valid) begin
          bus.trap_en = 1'b1;
          state_d     = BOUNDARY;
        end else if (bus.is_mret) begin
          bus.mret_en = 1'b1;
          bus.retire  = 1'b1;
          state_d     = BOUNDARY;
        end else if (bus.is_load || bus.is_store) begin
          state_d = MEM;
        end else if (bus.is_wfi) begin
          bus.pc_en  = 1'b1;
          bus.retire = 1'b1;
          state_d    = WFI;
        end else begin
          bus.pc_en  = 1'b1;
          bus.retire = 1'b1;
          bus.rd_en  = bus.has_rd;
          state_d    = BOUNDARY;
        end
      end

      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = bus.is_store;
        // A fault reported with dmem_ready suppresses every commit of the access.
        if (bus.dmem_ready) begin
          if (bus.exception_valid) begin
            bus.trap_en = 1'b1;
          end else begin
            bus.pc_en  = 1'b1;
            bus.retire = 1'b1;
            bus.rd_en  = bus.is_load & bus.has_rd;
          end
          state_d = BOUNDARY;
        end
      end

      WFI: begin
        if (bus.int_pending) begin
          state_d = BOUNDARY;
        end
      end

      default: begin
        state_d = BOUNDARY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOUNDARY;
    end else begin
      state_q <= state_d;
    end
  end

endmodule : core_controller

// File: tb/tb_core_controller.sv
// Randomized self-checking bench: per-instruction expected output traces built from the sequencing rules.
module tb_core_controller;

  localparam logic [9:0] O_IMEM  = 10'b10_0000_0000;
  localparam logic [9:0] O_DMEM  = 10'b01_0000_0000;
  localparam logic [9:0] O_WE    = 10'b00_1000_0000;
  localparam logic [9:0] O_CHK   = 10'b00_0100_0000;
  localparam logic [9:0] O_INSTR = 10'b00_0010_0000;
  localparam logic [9:0] O_PC    = 10'b00_0001_0000;
  localparam logic [9:0] O_RD    = 10'b00_0000_1000;
  localparam logic [9:0] O_RET   = 10'b00_0000_0100;
  localparam logic [9:0] O_TRAP  = 10'b00_0000_0010;
  localparam logic [9:0] O_MRET  = 10'b00_0000_0001;
  localparam logic [9:0] O_ALL   = 10'b11_1111_1111;
  localparam logic [9:0] O_NOREQ = O_ALL & ~(O_IMEM | O_DMEM | O_WE);

  typedef struct packed {
    logic rst;
    logic imem_ready;
    logic dmem_ready;
    logic is_load;
    logic is_store;
    logic is_mret;
    logic is_wfi;
    logic has_rd;
    logic exception_valid;
    logic interrupt_valid;
    logic int_pending;
  } stim_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_failures;

  core_controller_if bus();

  core_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] sample_outputs();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.check_interrupt, bus.instr_en,
            bus.pc_en, bus.rd_en, bus.retire, bus.trap_en, bus.mret_en};
  endfunction

  function automatic logic noise();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_failures++;
      $display("[TB] FAIL %s observed=%b expected=%b (imem,dmem,we,chk,instr,pc,rd,ret,trap,mret)",
               tag, observed, expected);
    end
  endtask

  // Called 1 time unit after a rising edge; drives one cycle, samples at the falling edge.
  task automatic applyStimulus(input string tag, input stim_t s, input logic [9:0] exp, input logic [9:0] care);
    rst                 = s.rst;
    bus.imem_ready      = s.imem_ready;
    bus.dmem_ready      = s.dmem_ready;
    bus.is_load         = s.is_load;
    bus.is_store        = s.is_store;
    bus.is_mret         = s.is_mret;
    bus.is_wfi          = s.is_wfi;
    bus.has_rd          = s.has_rd;
    bus.exception_valid = s.exception_valid;
    bus.interrupt_valid = s.interrupt_valid;
    bus.int_pending     = s.int_pending;
    #4;
    checkOutput(tag, sample_outputs() & care, exp & care);
    @(posedge clk);
    #1;
  endtask

  // Expected trace of one instruction, derived directly from the sequencing rules.
  task automatic run_instr(input bit take_irq, input int imem_wait,
                           input logic ld, input logic st, input logic mr, input logic wf,
                           input logic hrd, input logic exc_exec,
                           input int dmem_wait, input bit dmem_fault,
                           input int wfi_wait, input logic pend_at_exec);
    stim_t      s;
    logic [9:0] e;
    s          = '0;
    s.is_load  = ld;
    s.is_store = st;
    s.is_mret  = mr;
    s.is_wfi   = wf;
    s.has_rd   = hrd;

    s.interrupt_valid = take_irq;
    s.exception_valid = noise();
    applyStimulus("boundary", s, O_CHK | (take_irq ? O_TRAP : 10'd0), O_ALL);
    if (take_irq) return;

    for (int i = 0; i < imem_wait; i++) begin
      s.exception_valid = noise();
      s.interrupt_valid = noise();
      applyStimulus("fetch_wait", s, O_IMEM, O_ALL);
    end
    s.imem_ready      = 1'b1;
    s.exception_valid = noise();
    s.interrupt_valid = noise();
    applyStimulus("fetch_ready", s, O_IMEM | O_INSTR, O_ALL);
    s.imem_ready = 1'b0;

    s.exception_valid = exc_exec;
    s.interrupt_valid = noise();
    s.int_pending     = pend_at_exec;
    if (exc_exec)       e = O_TRAP;
    else if (mr)        e = O_MRET | O_RET;
    else if (ld || st)  e = '0;
    else if (wf)        e = O_PC | O_RET;
    else                e = O_PC | O_RET | (hrd ? O_RD : 10'd0);
    applyStimulus("exec", s, e, O_ALL);
    s.int_pending = 1'b0;
    if (exc_exec || mr) return;

    if (ld || st) begin
      for (int i = 0; i < dmem_wait; i++) begin
        s.exception_valid = noise();
        s.interrupt_valid = noise();
        applyStimulus("mem_wait", s, O_DMEM | (st ? O_WE : 10'd0), O_ALL);
      end
      s.dmem_ready      = 1'b1;
      s.exception_valid = dmem_fault;
      s.interrupt_valid = noise();
      e = O_DMEM | (st ? O_WE : 10'd0);
      e |= dmem_fault ? O_TRAP : (O_PC | O_RET | ((ld && hrd) ? O_RD : 10'd0));
      applyStimulus("mem_ready", s, e, O_ALL);
    end else if (wf) begin
      for (int i = 0; i < wfi_wait; i++) begin
        s.exception_valid = noise();
        s.interrupt_valid = noise();
        applyStimulus("wfi_sleep", s, '0, O_ALL);
      end
      s.int_pending     = 1'b1;
      s.interrupt_valid = noise();
      applyStimulus("wfi_wake", s, '0, O_ALL);
    end
  endtask

  task automatic reset_mid_mem();
    stim_t s;
    s          = '0;
    s.is_load  = 1'b1;
    s.has_rd   = 1'b1;
    applyStimulus("rstmem_boundary", s, O_CHK, O_ALL);
    s.imem_ready = 1'b1;
    applyStimulus("rstmem_fetch", s, O_IMEM | O_INSTR, O_ALL);
    s.imem_ready = 1'b0;
    applyStimulus("rstmem_exec", s, '0, O_ALL);
    applyStimulus("rstmem_wait", s, O_DMEM, O_ALL);
    s.rst = 1'b1;
    applyStimulus("rstmem_reset_cycle", s, O_CHK, O_NOREQ);
    s.rst = 1'b0;
    applyStimulus("rstmem_after_reset", s, O_CHK, O_ALL);
    s.imem_ready = 1'b1;
    applyStimulus("rstmem_refetch", s, O_IMEM | O_INSTR, O_ALL);
    s.imem_ready = 1'b0;
    s.is_load    = 1'b0;
    applyStimulus("rstmem_exec_alu", s, O_PC | O_RET | O_RD, O_ALL);
  endtask

  initial begin
    stim_t s;
    n_checks   = 0;
    n_failures = 0;
    s          = '0;
    s.rst      = 1'b1;
    rst        = 1'b1;
    bus.imem_ready = 1'b0;  bus.dmem_ready = 1'b0;  bus.is_load = 1'b0;
    bus.is_store = 1'b0;    bus.is_mret = 1'b0;     bus.is_wfi = 1'b0;
    bus.has_rd = 1'b0;      bus.exception_valid = 1'b0;
    bus.interrupt_valid = 1'b0;  bus.int_pending = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("reset_0", s, O_CHK, O_ALL);
    applyStimulus("reset_1", s, O_CHK, O_ALL);

    $display("[TB] directed sequences");
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    run_instr(0, 0, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0);
    run_instr(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    run_instr(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5, 1);
    run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    reset_mid_mem();

    $display("[TB] randomized sequences");
    for (int n = 0; n < 400; n++) begin
      run_instr($urandom_range(0, 7) == 0,
                int'($urandom_range(0, 2)),
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 4) == 0,
                noise(),
                $urandom_range(0, 5) == 0,
                int'($urandom_range(0, 3)),
                $urandom_range(0, 4) == 0,
                int'($urandom_range(0, 3)),
                noise());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule : tb_core_controller

// File: doc/core_controller.md
# core_controller

Multi-cycle sequencing FSM for the RV32 core. Steps each instruction through boundary check, fetch, execute and optional memory access. Handshakes with the instruction and data memory ports, and drives the register-file, PC and CSR commit strobes. Owns the `check_interrupt` strobe into the trap handler, and turns the trap handler's `exception_valid` / `interrupt_valid` into a single-cycle trap-entry pulse for the CSR block.

## Interface
- No parameters.
- `clk` in 1: core clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: instruction fetch request; held until `imem_ready`.
- `imem_ready` in 1: fetch completes this cycle (data or access fault valid).
- `dmem_req` out 1: data access request; held until `dmem_ready`.
- `dmem_we` out 1: data access is a store (valid with `dmem_req`).
- `dmem_ready` in 1: data access completes this cycle (data or access fault valid).
- `is_load`, `is_store`, `is_mret`, `is_wfi` in 1 each: decoded class of the latched instruction.
- `has_rd` in 1: instruction writes a destination register.
- `exception_valid` in 1: any exception (from trap handler).
- `interrupt_valid` in 1: enabled interrupt pending (from trap handler, gated by `check_interrupt`).
- `int_pending` in 1: raw pending interrupt, ignoring enables (WFI wake-up).
- `check_interrupt` out 1: to trap handler.
- `instr_en` out 1: latch the fetched instruction.
- `pc_en` out 1: commit `pc_new` to the PC.
- `rd_en` out 1: register-file write enable.
- `retire` out 1: instruction retired (minstret increment).
- `trap_en` out 1: CSR captures cause/value/epc; PC ← mtvec.
- `mret_en` out 1: CSR restores mstatus; PC ← mepc.

## Operation
- States (`ctrl_state_e`):
  - `BOUNDARY`
    - `check_interrupt`=1.
    - `interrupt_valid` → `trap_en`, next `BOUNDARY`.
    - Otherwise next `FETCH`.
  - `FETCH`
    - `imem_req`=1.
    - On `imem_ready`: `instr_en`=1, next `EXEC`; else stay.
  - `EXEC` (one cycle), priority in this order:
    1. `exception_valid` → `trap_en`, next `BOUNDARY`. Covers fetch fault, illegal instruction, misaligned, ecall, ebreak.
    2. `is_mret` → `mret_en`, `retire`, next `BOUNDARY`.
    3. `is_load` or `is_store` → next `MEM`.
    4. `is_wfi` → `pc_en`, `retire`, next `WFI`.
    5. Otherwise → `pc_en`, `retire`, `rd_en`=`has_rd`, next `BOUNDARY`.
  - `MEM`
    - `dmem_req`=1; `dmem_we`=`is_store`.
    - On `dmem_ready` with `exception_valid` (access fault): `trap_en`, no `rd_en`/`pc_en`/`retire`, next `BOUNDARY`.
    - On `dmem_ready` without fault: `pc_en`, `retire`, `rd_en`=`is_load & has_rd`, next `BOUNDARY`.
    - Otherwise stay with request held.
  - `WFI`
    - Next `BOUNDARY` when `int_pending`=1, else stay.
    - `check_interrupt`=0 here. The interrupt is taken in the following `BOUNDARY`.
- Strobe rules:
  - At most one of `trap_en`, `mret_en`, `pc_en` per cycle.
  - `rd_en` and `retire` are never asserted with `trap_en`.
  - All strobes are combinational from state and inputs; only the state is registered.
- `exception_valid` is sampled only in `EXEC` and in `MEM` on `dmem_ready`. It is ignored elsewhere.
- `interrupt_valid` is acted on only in `BOUNDARY`.

## Timing
- Reset:
  - State ← `BOUNDARY`.
  - In the reset cycle and the cycle after, `check_interrupt`=1. All other outputs are 0 unless the `BOUNDARY` rules assert `trap_en`.
  - Reset during `FETCH`/`MEM` drops the request the next cycle, with no commit.
- Cycle counts:
  - Non-memory instruction with zero-wait memory: 3 cycles (`BOUNDARY`, `FETCH`, `EXEC`).
  - Load/store with zero-wait memory: 4 cycles.
  - Each wait cycle on `imem_ready`/`dmem_ready` adds one.
- Requests are asserted combinationally on state entry. They deassert the cycle after the ready cycle, never before ready.
- Interrupt and exception in the same instruction: the interrupt wins, because it is taken in `BOUNDARY` before fetch.
- `int_pending` and WFI entry in the same cycle: the pending input is ignored in `EXEC`. Wake occurs one cycle later in `WFI`.

## Structure
- `ctrl_state_e` (5 states, 3-bit encoding) goes in `core_pkg`.
- No sub-module: a single FSM with one registered state and combinational output decode.

## Test plan
- ADD with zero-wait memories:
  - `imem_ready`=1 in the first `FETCH` cycle.
  - Required: `instr_en` at cycle 2, then `pc_en`/`rd_en`/`retire` at cycle 3, then `check_interrupt` at cycle 4.
- Load with `dmem_ready` delayed 3 cycles:
  - `dmem_req` held 4 cycles.
  - `rd_en`, `pc_en` and `retire` occur only in the ready cycle.
- Store with `exception_valid`=1 at `dmem_ready`:
  - `trap_en`=1 in that cycle.
  - `rd_en`=`pc_en`=`retire`=0.
  - Next state `BOUNDARY`.
- Illegal instruction with `exception_valid`=1 in `EXEC`, also `is_load`=1:
  - `trap_en`=1 and no `dmem_req` ever.
- WFI, then `int_pending` raised 5 cycles later with `interrupt_valid`=1:
  - `retire` in `EXEC`.
  - Stays in `WFI` 5 cycles.
  - `trap_en` in the following `BOUNDARY` cycle, with no `imem_req` in between.
- `rst` pulsed mid-`MEM` with `dmem_ready`=0:
  - `dmem_req` drops next cycle.
  - `check_interrupt`=1.
  - No commit strobes.
